la_ioseq: RTL and testbench
===========================

# la_ioseq

Power-sequencing controller for the IO pad ring. It brings up the IO supply segments one ring side at a time: it enables a side, waits for that side's power-good, then lets it settle before moving to the next. Only after every side is up does it release core/IO isolation. Power-down, abort and brownout handling all run in reverse order. It sits between the chip power-management logic and the per-side IO supply pad groups (vddio/vssio pads on NO/SO/EA/WE).

## Interface
Parameters:
- NSIDES, 4: number of independently sequenced ring sides (1..8); index 0 is powered first.
- SETTLE, 16: settle cycles after each power-good or before each disable (≥1).
- TIMEOUT, 256: maximum cycles to wait for a side's power-good (≥2).
- CW, 16: timer width; must hold max(SETTLE, TIMEOUT).

Ports:
- clk  input  1  clock; one clock domain.
- reset  input  1  synchronous, active-high reset.
- pwr_req  input  1  level request: 1 = ring powered, 0 = ring off.
- pgood  input  NSIDES  per-side power-good.
- side_en  output  NSIDES  per-side supply enable; reset 0.
- iso  output  1  core/IO isolation, 1 = isolated; reset 1.
- ready  output  1  ring fully up and isolation released; reset 0.
- busy  output  1  power-up or power-down in progress; reset 0.
- fault  output  1  sticky fault flag; reset 0.
- fault_side  output  NSIDES  one-hot side that caused the fault; reset 0.

## Operation
All outputs are registered. There is one FSM, a side index idx, and a CW-bit timer.

- **OFF**
  - All outputs are at their reset values.
  - When pwr_req=1: set side_en[0], idx=0, timer=0, go to RAMP.
- **RAMP**
  - Timer increments each cycle.
  - If pgood[idx]=1 is sampled: timer=0, go to SETTLE.
  - Otherwise, when timer==TIMEOUT-1: go to FAULT with fault_side[idx] set.
- **SETTLE**
  - Timer counts SETTLE cycles.
  - At the end, if idx<NSIDES-1: idx++, set side_en[idx], go to RAMP.
  - At the end, if idx==NSIDES-1: go to ON.
- **ON**
  - iso=0, ready=1, busy=0.
  - If pwr_req=0: go to DOWN.
- **DOWN**
  - iso=1 and ready=0 on the first cycle.
  - Each step waits SETTLE cycles, then clears side_en[idx].
  - After clearing, if idx>0 then idx-- and repeat; otherwise go to OFF.
- **FAULT**
  - side_en=0, iso=1, ready=0, busy=0, fault=1; fault_side holds its value.
  - When pwr_req=0 is sampled: go to OFF, and fault and fault_side clear.
- busy=1 in RAMP, SETTLE and DOWN.
- Brownout: in RAMP, SETTLE or ON, a side with side_en=1 whose pgood is sampled 0 forces FAULT. This excludes the current RAMP side.
  - fault_side is that side's one-hot value.
  - If several sides drop at once, the lowest index wins.
- Abort: pwr_req=0 sampled in RAMP or SETTLE goes to DOWN from the current idx. The side being ramped is included in the power-down.
- Abort during power-down: pwr_req=1 in DOWN is ignored. Power-down completes to OFF, and sequencing restarts from OFF.
- Priority within one cycle: brownout/timeout > pwr_req change > normal progress.
- reset at any time (mid-ramp, ON or FAULT) returns the block to OFF with reset output values on the next cycle.

## Timing
- Latency from pwr_req=1 sampled in OFF to side_en[0]=1: 1 cycle.
- Per side, pgood sampled at cycle t means:
  - SETTLE occupies t+1..t+SETTLE;
  - side_en[idx+1] (or ready/iso=0) is visible at t+SETTLE+1.
- Timeout: side_en[k] is visible at cycle s; with no pgood, fault=1 and side_en=0 at s+TIMEOUT.
- Power-down:
  - pwr_req=0 sampled at cycle t gives iso=1, ready=0 at t+1;
  - the highest side clears at t+1+SETTLE, then one side per SETTLE cycles.
- Brownout seen at cycle t gives fault, side_en=0 and iso=1 at t+1.
- The timer saturates and never wraps.
- The timer resets to 0 on every state transition.

## Configuration
- LA_IOSEQ_SYNC_EN
  - Defined: pwr_req and each pgood bit pass through 2-flop synchronizers (reset to 0) before the FSM. This adds 2 cycles to every input-to-output latency above.
  - Undefined: inputs are sampled directly and must already be synchronous to clk.

## Test plan
Default bench settings: NSIDES=4, SETTLE=4, TIMEOUT=8, LA_IOSEQ_SYNC_EN undefined. pwr_req rises at cycle 0, and each pgood[k] rises 2 cycles after side_en[k].

1. Power-up: side_en = 0001@1, 0011@8, 0111@15, 1111@22; iso=0 and ready=1 @29; busy=1 over cycles 1–28.
2. Timeout: pgood[1] held at 0 → fault=1, fault_side=0010, side_en=0000, iso=1 @16. Dropping pwr_req @20 → fault=0 @21, back in OFF.
3. Power-down: from ON, pwr_req=0 @40 → iso=1, ready=0 @41; side_en = 0111@45, 0011@49, 0001@53, 0000@57; busy=0 @57.
4. Brownout: in ON, pgood[2]=0 for one cycle @40 → fault=1, fault_side=0100, side_en=0000 @41. Fault stays set until pwr_req=0.
5. Abort: pwr_req=0 @9 (side 1 ramping) → side_en=0001 @14, 0000 @18, OFF. Re-raising pwr_req @11 has no effect until OFF is reached.
6. Reset: reset=1 @20 mid-sequence → all outputs at reset values @21. With pwr_req still 1, side_en=0001 @22 after reset is released @21.

Source files
------------

// File: rtl/la_ioseq.sv
// IO pad-ring power sequencer: enables ring sides in order, waits for power-good and settle, then releases isolation.
// Optional input synchronizers are compiled in with `define LA_IOSEQ_SYNC_EN.
module la_ioseq #(
  parameter int NSIDES  = 4,
  parameter int SETTLE  = 16,
  parameter int TIMEOUT = 256,
  parameter int CW      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pwr_req,
  input  logic [NSIDES-1:0] pgood,
  output logic [NSIDES-1:0] side_en,
  output logic              iso,
  output logic              ready,
  output logic              busy,
  output logic              fault,
  output logic [NSIDES-1:0] fault_side,
  output logic [2:0]        dbg_state
);

  localparam int IW = (NSIDES > 1) ? $clog2(NSIDES) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] ST_LAST = CW'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_OFF    = 3'd0,
    S_RAMP   = 3'd1,
    S_SETTLE = 3'd2,
    S_ON     = 3'd3,
    S_DOWN   = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  logic              req_s;
  logic [NSIDES-1:0] pg_s;

`ifdef LA_IOSEQ_SYNC_EN
  logic [1:0]        req_ff;
  logic [NSIDES-1:0] pg_ff1;
  logic [NSIDES-1:0] pg_ff2;

  always_ff @(posedge clk) begin
    if (reset) begin
      req_ff <= '0;
      pg_ff1 <= '0;
      pg_ff2 <= '0;
    end else begin
      req_ff <= {req_ff[0], pwr_req};
      pg_ff1 <= pgood;
      pg_ff2 <= pg_ff1;
    end
  end

  assign req_s = req_ff[1];
  assign pg_s  = pg_ff2;
`else
  assign req_s = pwr_req;
  assign pg_s  = pgood;
`endif

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     timer_q, timer_d, timer_inc;
  logic [NSIDES-1:0] side_en_q, side_en_d;
  logic              iso_q, iso_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              fault_q, fault_d;
  logic [NSIDES-1:0] fault_side_q, fault_side_d;

  logic [NSIDES-1:0] idx_hot;
  logic [NSIDES-1:0] brown;
  logic [NSIDES-1:0] brown_low;
  logic [NSIDES-1:0] fault_hot;
  logic              go_fault;
  logic              go_down;

  assign timer_inc = (timer_q == {CW{1'b1}}) ? timer_q : timer_q + CW'(1);
  assign idx_hot   = NSIDES'(1) << idx_q;

  // The side currently ramping has no power-good yet, so it cannot brown out.
  assign brown     = side_en_q & ~pg_s & ((state_q == S_RAMP) ? ~idx_hot : {NSIDES{1'b1}});
  assign brown_low = brown & (~brown + NSIDES'(1));

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    timer_d      = timer_inc;
    side_en_d    = side_en_q;
    iso_d        = iso_q;
    ready_d      = ready_q;
    busy_d       = busy_q;
    fault_d      = fault_q;
    fault_side_d = fault_side_q;
    go_fault     = 1'b0;
    go_down      = 1'b0;
    fault_hot    = '0;

    case (state_q)
      S_OFF: begin
        side_en_d    = '0;
        iso_d        = 1'b1;
        ready_d      = 1'b0;
        busy_d       = 1'b0;
        fault_d      = 1'b0;
        fault_side_d = '0;
        idx_d        = '0;
        timer_d      = '0;
        if (req_s) begin
          side_en_d = NSIDES'(1);
          busy_d    = 1'b1;
          state_d   = S_RAMP;
        end
      end

      S_RAMP: begin
        if (|brown) begin
          go_fault  = 1'b1;
          fault_hot = brown_low;
        end else if ((timer_q == TO_LAST) && !pg_s[idx_q]) begin
          go_fault  = 1'b1;
          fault_hot = idx_hot;
        end else if (!req_s) begin
          go_down = 1'b1;
        end else if (pg_s[idx_q]) begin
          state_d = S_SETTLE;
          timer_d = '0;
        end
      end

      S_SETTLE: begin
        if (|brown) begin
          go_fault  = 1'b1;
          fault_hot = brown_low;
        end else if (!req_s) begin
          go_down = 1'b1;
        end else if (timer_q == ST_LAST) begin
          timer_d = '0;
          if (idx_q < IW'(NSIDES - 1)) begin
            idx_d     = idx_q + IW'(1);
            side_en_d = side_en_q | (idx_hot << 1);
            state_d   = S_RAMP;
          end else begin
            iso_d   = 1'b0;
            ready_d = 1'b1;
            busy_d  = 1'b0;
            state_d = S_ON;
          end
        end
      end

      S_ON: begin
        if (|brown) begin
          go_fault  = 1'b1;
          fault_hot = brown_low;
        end else if (!req_s) begin
          go_down = 1'b1;
        end
      end

      // Power-down always runs to completion; a new request is honoured from OFF.
      S_DOWN: begin
        if (timer_q == ST_LAST) begin
          side_en_d = side_en_q & ~idx_hot;
          timer_d   = '0;
          if (idx_q == '0) begin
            busy_d  = 1'b0;
            state_d = S_OFF;
          end else begin
            idx_d = idx_q - IW'(1);
          end
        end
      end

      S_FAULT: begin
        if (!req_s) begin
          fault_d      = 1'b0;
          fault_side_d = '0;
          timer_d      = '0;
          state_d      = S_OFF;
        end
      end

      default: begin
        state_d = S_OFF;
        timer_d = '0;
      end
    endcase

    if (go_fault) begin
      state_d      = S_FAULT;
      side_en_d    = '0;
      iso_d        = 1'b1;
      ready_d      = 1'b0;
      busy_d       = 1'b0;
      fault_d      = 1'b1;
      fault_side_d = fault_hot;
      timer_d      = '0;
    end else if (go_down) begin
      state_d = S_DOWN;
      iso_d   = 1'b1;
      ready_d = 1'b0;
      busy_d  = 1'b1;
      timer_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_OFF;
      idx_q        <= '0;
      timer_q      <= '0;
      side_en_q    <= '0;
      iso_q        <= 1'b1;
      ready_q      <= 1'b0;
      busy_q       <= 1'b0;
      fault_q      <= 1'b0;
      fault_side_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      timer_q      <= timer_d;
      side_en_q    <= side_en_d;
      iso_q        <= iso_d;
      ready_q      <= ready_d;
      busy_q       <= busy_d;
      fault_q      <= fault_d;
      fault_side_q <= fault_side_d;
    end
  end

  assign side_en    = side_en_q;
  assign iso        = iso_q;
  assign ready      = ready_q;
  assign busy       = busy_q;
  assign fault      = fault_q;
  assign fault_side = fault_side_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_la_ioseq.sv
// Directed bench for la_ioseq: per-scenario input schedules plus a table of expected outputs at given cycles.
module tb_la_ioseq;

  localparam int NS = 4;
  localparam int ST = 4;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          pwr_req;
  logic [NS-1:0] pgood;
  logic [NS-1:0] side_en;
  logic          iso;
  logic          ready;
  logic          busy;
  logic          fault;
  logic [NS-1:0] fault_side;
  logic [2:0]    dbg_state;

  always #5 clk = ~clk;

  la_ioseq #(.NSIDES(NS), .SETTLE(ST), .TIMEOUT(TO), .CW(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .pwr_req   (pwr_req),
    .pgood     (pgood),
    .side_en   (side_en),
    .iso       (iso),
    .ready     (ready),
    .busy      (busy),
    .fault     (fault),
    .fault_side(fault_side),
    .dbg_state (dbg_state)
  );

  // Expected word layout: {side_en[3:0], iso, ready, busy, fault, fault_side[3:0]}
  typedef struct {
    int         scen;
    int         cyc;
    logic [11:0] exp;
  } vec_t;

  typedef struct {
    int         length;
    int         off_cyc;
    int         on_cyc;
    logic [3:0] stuck;
    int         glitch_side;
    int         glitch_cyc;
    int         rst_cyc;
  } scen_t;

  vec_t        vecs[$];
  scen_t       scens[1:6];
  logic [11:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          age[NS];

  function automatic logic [11:0] pack(logic [3:0] se, logic i, logic r, logic b, logic f, logic [3:0] fs);
    return {se, i, r, b, f, fs};
  endfunction

  task automatic add(input int s, input int c, input logic [3:0] se, input logic i, input logic r,
                     input logic b, input logic f, input logic [3:0] fs);
    vec_t v;
    v.scen = s;
    v.cyc  = c;
    v.exp  = pack(se, i, r, b, f, fs);
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got se=%b iso=%b rdy=%b busy=%b flt=%b fs=%b, want se=%b iso=%b rdy=%b busy=%b flt=%b fs=%b",
               name, act[11:8], act[7], act[6], act[5], act[4], act[3:0],
               exp[11:8], exp[7], exp[6], exp[5], exp[4], exp[3:0]);
    end
  endtask

  task automatic run_scen(input int s);
    scen_t       sc;
    logic [11:0] obs;
    logic [11:0] e;
    int          busy_bad;
    sc = scens[s];
    busy_bad = 0;
    reset   = 1'b1;
    pwr_req = 1'b0;
    pgood   = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int k = 0; k < NS; k++) age[k] = 0;
    @(posedge clk);
    #1;
    for (int c = 0; c < sc.length; c++) begin
      obs = pack(side_en, iso, ready, busy, fault, fault_side);
      foreach (vecs[i]) begin
        if (vecs[i].scen == s && vecs[i].cyc == c) exp_q.push_back(vecs[i].exp);
      end
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check($sformatf("scen%0d_cyc%0d", s, c), obs, e);
      end
      if (s == 1) begin
        if (c >= 1 && c <= 28 && busy !== 1'b1) busy_bad++;
        if (c >= 29 && busy !== 1'b0) busy_bad++;
      end
      // Supply model: each pgood follows its enable after two cycles.
      for (int k = 0; k < NS; k++) begin
        age[k]   = side_en[k] ? age[k] + 1 : 0;
        pgood[k] = (age[k] >= 3) && !sc.stuck[k] && !(k == sc.glitch_side && c == sc.glitch_cyc);
      end
      pwr_req = !(sc.off_cyc >= 0 && c >= sc.off_cyc && !(sc.on_cyc >= 0 && c >= sc.on_cyc));
      reset   = (c == sc.rst_cyc);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    if (s == 1) begin
      n_checks++;
      if (busy_bad != 0) begin
        n_fail++;
        $display("FAIL busy_window: %0d bad cycles, want 0", busy_bad);
      end
    end
  endtask

  initial begin
    reset   = 1'b1;
    pwr_req = 1'b0;
    pgood   = '0;

    scens[1] = '{32, -1, -1, 4'b0000, -1, -1, -1};
    scens[2] = '{24, 20, -1, 4'b0010, -1, -1, -1};
    scens[3] = '{60, 40, -1, 4'b0000, -1, -1, -1};
    scens[4] = '{48, 45, -1, 4'b0000,  2, 40, -1};
    scens[5] = '{22,  9, 11, 4'b0000, -1, -1, -1};
    scens[6] = '{24, -1, -1, 4'b0000, -1, -1, 20};

    // power-up
    add(1,  0, 4'b0000, 1, 0, 0, 0, 4'b0000);
    add(1,  1, 4'b0001, 1, 0, 1, 0, 4'b0000);
    add(1,  7, 4'b0001, 1, 0, 1, 0, 4'b0000);
    add(1,  8, 4'b0011, 1, 0, 1, 0, 4'b0000);
    add(1, 15, 4'b0111, 1, 0, 1, 0, 4'b0000);
    add(1, 22, 4'b1111, 1, 0, 1, 0, 4'b0000);
    add(1, 28, 4'b1111, 1, 0, 1, 0, 4'b0000);
    add(1, 29, 4'b1111, 0, 1, 0, 0, 4'b0000);
    add(1, 31, 4'b1111, 0, 1, 0, 0, 4'b0000);
    // timeout on side 1
    add(2,  8, 4'b0011, 1, 0, 1, 0, 4'b0000);
    add(2, 15, 4'b0011, 1, 0, 1, 0, 4'b0000);
    add(2, 16, 4'b0000, 1, 0, 0, 1, 4'b0010);
    add(2, 20, 4'b0000, 1, 0, 0, 1, 4'b0010);
    add(2, 21, 4'b0000, 1, 0, 0, 0, 4'b0000);
    // power-down from ON
    add(3, 40, 4'b1111, 0, 1, 0, 0, 4'b0000);
    add(3, 41, 4'b1111, 1, 0, 1, 0, 4'b0000);
    add(3, 44, 4'b1111, 1, 0, 1, 0, 4'b0000);
    add(3, 45, 4'b0111, 1, 0, 1, 0, 4'b0000);
    add(3, 49, 4'b0011, 1, 0, 1, 0, 4'b0000);
    add(3, 53, 4'b0001, 1, 0, 1, 0, 4'b0000);
    add(3, 57, 4'b0000, 1, 0, 0, 0, 4'b0000);
    add(3, 59, 4'b0000, 1, 0, 0, 0, 4'b0000);
    // brownout of side 2 while ON
    add(4, 40, 4'b1111, 0, 1, 0, 0, 4'b0000);
    add(4, 41, 4'b0000, 1, 0, 0, 1, 4'b0100);
    add(4, 44, 4'b0000, 1, 0, 0, 1, 4'b0100);
    add(4, 45, 4'b0000, 1, 0, 0, 1, 4'b0100);
    add(4, 46, 4'b0000, 1, 0, 0, 0, 4'b0000);
    // abort while side 1 ramps, re-request ignored until OFF
    add(5,  8, 4'b0011, 1, 0, 1, 0, 4'b0000);
    add(5,  9, 4'b0011, 1, 0, 1, 0, 4'b0000);
    add(5, 10, 4'b0011, 1, 0, 1, 0, 4'b0000);
    add(5, 13, 4'b0011, 1, 0, 1, 0, 4'b0000);
    add(5, 14, 4'b0001, 1, 0, 1, 0, 4'b0000);
    add(5, 17, 4'b0001, 1, 0, 1, 0, 4'b0000);
    add(5, 18, 4'b0000, 1, 0, 0, 0, 4'b0000);
    add(5, 19, 4'b0001, 1, 0, 1, 0, 4'b0000);
    // synchronous reset mid-sequence
    add(6, 20, 4'b0111, 1, 0, 1, 0, 4'b0000);
    add(6, 21, 4'b0000, 1, 0, 0, 0, 4'b0000);
    add(6, 22, 4'b0001, 1, 0, 1, 0, 4'b0000);

    for (int s = 1; s <= 6; s++) run_scen(s);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
